// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage PC sequencer: IDLE/RUN control, branch/stall/halt priority, run-cycle counter.
// Optional 4-entry return-address stack enabled by `define FETCH_CALL_STACK_EN.
module inst_fetch_ctrl #(
  parameter int           A          = 10,
  parameter logic [A-1:0] START_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [A-1:0] Target,
  input  logic         Call,
  input  logic         Ret,
  input  logic         Halt,
  output logic [A-1:0] InstAddress,
  output logic         FetchValid,
  output logic         Busy,
  output logic         Done,
  output logic [15:0]  CycleCount,
  output logic         StackErr
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic halt;
    logic stall;
    logic call;
    logic ret;
    logic br_en;
    logic br_rel;
  } ctrl_t;

  state_t       state_q, state_d;
  ctrl_t        ctrl;
  logic [A-1:0] pc_d, pc_inc;
  logic         done_d;
  logic         clr;

  assign ctrl   = '{halt: Halt, stall: Stall, call: Call, ret: Ret,
                    br_en: BranchEn, br_rel: BranchRel};
  assign pc_inc = InstAddress + A'(1);

`ifdef FETCH_CALL_STACK_EN
  logic [3:0][A-1:0] stk;
  logic [1:0]        top;
  logic [2:0]        depth;
  logic              push, pop, err_q;
  logic              stk_empty, stk_full;
  logic [A-1:0]      tos;

  assign stk_empty = (depth == 3'd0);
  assign stk_full  = (depth == 3'd4);
  assign tos       = stk[top - 2'd1];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = InstAddress;
    done_d  = 1'b0;
    clr     = 1'b0;
`ifdef FETCH_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        pc_d = START_ADDR;
        if (Start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (ctrl.halt) begin
          state_d = IDLE;
          pc_d    = START_ADDR;
          done_d  = 1'b1;
        end else if (ctrl.stall) begin
          pc_d = InstAddress;
`ifdef FETCH_CALL_STACK_EN
        end else if (ctrl.call) begin
          push = 1'b1;
          pc_d = Target;
        end else if (ctrl.ret) begin
          pop  = 1'b1;
          pc_d = stk_empty ? pc_inc : tos;
`endif
        end else if (ctrl.br_en) begin
          // A-bit add: sign extension of the offset is implicit modulo 2^A
          pc_d = ctrl.br_rel ? (InstAddress + Target) : Target;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      InstAddress <= START_ADDR;
      Done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      InstAddress <= pc_d;
      Done        <= done_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      CycleCount <= 16'h0000;
    else if (clr)
      CycleCount <= 16'h0000;
    else if (state_q == RUN && CycleCount != 16'hFFFF)
      CycleCount <= CycleCount + 16'h0001;
  end

  assign Busy       = (state_q == RUN);
  assign FetchValid = (state_q == RUN);

`ifdef FETCH_CALL_STACK_EN
  // Circular buffer: once full, top points at the oldest slot, so a push overwrites it
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stk   <= '0;
      top   <= 2'd0;
      depth <= 3'd0;
      err_q <= 1'b0;
    end else if (clr) begin
      top   <= 2'd0;
      depth <= 3'd0;
      err_q <= 1'b0;
    end else if (push) begin
      stk[top] <= pc_inc;
      top      <= top + 2'd1;
      if (stk_full) err_q <= 1'b1;
      else          depth <= depth + 3'd1;
    end else if (pop) begin
      if (stk_empty) begin
        err_q <= 1'b1;
      end else begin
        top   <= top - 2'd1;
        depth <= depth - 3'd1;
      end
    end
  end

  assign StackErr = err_q;
`else
  logic unused_stack_ctrl;
  assign unused_stack_ctrl = ctrl.call ^ ctrl.ret;
  assign StackErr          = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a behavioural model pushes the expected
// post-edge state per driven cycle; it is popped and compared one edge later.
module tb_inst_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, Stall, BranchEn, BranchRel, Call, Ret, Halt;
  logic [9:0]  Target;
  logic [9:0]  InstAddress;
  logic        FetchValid, Busy, Done, StackErr;
  logic [15:0] CycleCount;

  inst_fetch_ctrl #(.A(10), .START_ADDR(10'd0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .BranchEn(BranchEn), .BranchRel(BranchRel), .Target(Target),
    .Call(Call), .Ret(Ret), .Halt(Halt), .InstAddress(InstAddress),
    .FetchValid(FetchValid), .Busy(Busy), .Done(Done),
    .CycleCount(CycleCount), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  pc;
    logic [19:0] stat;  // {busy, fetch_valid, done, stack_err, cycle_count}
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  // reference model state
  logic        m_run, m_done, m_err;
  logic [9:0]  m_pc;
  logic [15:0] m_cnt;
  logic [9:0]  m_stk[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_pc = 10'd0; m_cnt = 16'd0;
    m_stk.delete();
  endtask

  // One clock: apply inputs, predict, wait for the edge, compare.
  task automatic drive(input logic st, sl, be, br, input logic [9:0] tg,
                       input logic cl, rt, hl);
    exp_t e, o;
    Start = st; Stall = sl; BranchEn = be; BranchRel = br; Target = tg;
    Call = cl; Ret = rt; Halt = hl;
    m_done = 0;
    if (!m_run) begin
      m_pc = 10'd0;
      if (st) begin
        m_run = 1; m_cnt = 16'd0; m_err = 0; m_stk.delete();
      end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (hl) begin
        m_run = 0; m_pc = 10'd0; m_done = 1;
      end else if (sl) begin
        m_pc = m_pc;
`ifdef FETCH_CALL_STACK_EN
      end else if (cl) begin
        if (m_stk.size() == 4) begin
          void'(m_stk.pop_front());
          m_err = 1;
        end
        m_stk.push_back(m_pc + 10'd1);
        m_pc = tg;
      end else if (rt) begin
        if (m_stk.size() == 0) begin
          m_pc = m_pc + 10'd1;
          m_err = 1;
        end else begin
          m_pc = m_stk.pop_back();
        end
`endif
      end else if (be) begin
        m_pc = br ? 10'((int'(m_pc) + int'($signed(tg))) & 32'h3FF) : tg;
      end else begin
        m_pc = m_pc + 10'd1;
      end
    end
    e.pc   = m_pc;
    e.stat = {m_run, m_run, m_done, m_err, m_cnt};
    sb.push_back(e);
    @(posedge Clk);
    #1;
    o = sb.pop_front();
    chk("pc", 32'(InstAddress), 32'(o.pc));
    chk("stat", 32'({Busy, FetchValid, Done, StackErr, CycleCount}), 32'(o.stat));
  endtask

  task automatic step();
    drive(0, 0, 0, 0, 10'd0, 0, 0, 0);
  endtask

  task automatic start_run();
    drive(1, 0, 0, 0, 10'd0, 0, 0, 0);
  endtask

  task automatic jump(input logic [9:0] a);
    drive(0, 0, 1, 0, a, 0, 0, 0);
  endtask

  initial begin
    Reset_n = 0;
    Start = 0; Stall = 0; BranchEn = 0; BranchRel = 0; Target = '0;
    Call = 0; Ret = 0; Halt = 0;
    model_reset();
    #12;
    chk("rst_pc", 32'(InstAddress), 32'd0);
    chk("rst_flags", 32'({Busy, FetchValid, Done, StackErr}), 32'd0);
    chk("rst_cnt", 32'(CycleCount), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1;

    // idle, then basic run 0,1,2,3 with halt at 3
    step();
    start_run();
    repeat (3) step();
    chk("pc_at3", 32'(InstAddress), 32'd3);
    drive(0, 0, 0, 0, 10'd0, 0, 0, 1);
    chk("halt_pc", 32'(InstAddress), 32'd0);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_cnt", 32'(CycleCount), 32'd4);
    step();
    chk("done_pulse", 32'(Done), 32'd0);

    // relative and absolute branches from PC 5
    start_run();
    repeat (5) step();
    drive(0, 0, 1, 1, 10'h3FE, 0, 0, 0);
    chk("rel_back", 32'(InstAddress), 32'd3);
    repeat (2) step();
    jump(10'd200);
    chk("abs_br", 32'(InstAddress), 32'd200);

    // stall beats branch for two cycles
    jump(10'd7);
    repeat (2) drive(0, 1, 1, 0, 10'd100, 0, 0, 0);
    chk("stall_pc", 32'(InstAddress), 32'd7);
    step();
    chk("post_stall", 32'(InstAddress), 32'd8);

    // wrap-around: increment and relative in both directions
    jump(10'd1023);
    step();
    chk("wrap_inc", 32'(InstAddress), 32'd0);
    drive(0, 0, 1, 1, 10'h3FF, 0, 0, 0);
    chk("wrap_rel_dn", 32'(InstAddress), 32'd1023);
    drive(0, 0, 1, 1, 10'd2, 0, 0, 0);
    chk("wrap_rel_up", 32'(InstAddress), 32'd1);

    // Start in RUN ignored; Call/Ret ignored without the stack
    drive(1, 0, 0, 0, 10'd0, 0, 0, 0);
`ifndef FETCH_CALL_STACK_EN
    drive(0, 0, 0, 0, 10'd50, 1, 0, 0);
    drive(0, 0, 0, 0, 10'd50, 0, 1, 0);
    chk("no_stack", 32'(InstAddress), 32'd4);
`endif
    // Halt with Start: halt wins, stays idle
    drive(1, 0, 0, 0, 10'd0, 0, 0, 1);
    step();
    chk("halt_start_idle", 32'(Busy), 32'd0);

`ifdef FETCH_CALL_STACK_EN
    start_run();
    repeat (4) step();
    drive(0, 0, 0, 0, 10'd50, 1, 0, 0);
    chk("call_pc", 32'(InstAddress), 32'd50);
    drive(0, 0, 0, 0, 10'd0, 0, 1, 0);
    chk("ret_pc", 32'(InstAddress), 32'd5);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 10'(100 + 10 * i), 1, 1, 0);
    chk("ovf_err", 32'(StackErr), 32'd1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 10'd0, 0, 1, 0);
    drive(0, 0, 0, 0, 10'd0, 0, 0, 1);
    start_run();
    chk("err_clr", 32'(StackErr), 32'd0);
    step();
    drive(0, 0, 0, 0, 10'd0, 0, 1, 0);
    chk("unf_pc", 32'(InstAddress), 32'd2);
    chk("unf_err", 32'(StackErr), 32'd1);
    drive(0, 0, 0, 0, 10'd0, 0, 0, 1);
`endif

    // counter saturation
    start_run();
    repeat (65540) step();
    chk("cnt_sat", 32'(CycleCount), 32'hFFFF);
    step();
    chk("cnt_hold", 32'(CycleCount), 32'hFFFF);

    // asynchronous reset between edges
    start_run();
    repeat (3) step();
    #3;
    Reset_n = 0;
    #1;
    chk("arst_pc", 32'(InstAddress), 32'd0);
    chk("arst_flags", 32'({Busy, FetchValid, Done, StackErr}), 32'd0);
    chk("arst_cnt", 32'(CycleCount), 32'd0);
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1;
    step();
    chk("arst_idle", 32'(Busy), 32'd0);
    start_run();
    step();
    chk("resume_pc", 32'(InstAddress), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
